// File: rtl/wide_arith_seq_if.sv
// Bus bundle for the 16-bit add/subtract sequencer: request side,
// 8-bit ALU drive/return side and result side.
//
// Handshake: Start is a request that is accepted only while Busy is low
// (the sequencer is idle). Nothing queues, so a request made while Busy
// is high is dropped. The operands must be valid in the accepting cycle.
// Done is a one-cycle valid strobe. Result and the flags are valid while
// Done is high and stay held until the next accepted Start.
interface wide_arith_seq_if;
  logic        Start;
  logic        OpSub;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [7:0]  AluA;
  logic [7:0]  AluB;
  logic        AluOp;
  logic [7:0]  AluOut;
  logic        AluLT;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;
  logic        ZeroOut;
  logic        LTOut;
  logic        CarryOut;

  // Sequencer side
  modport slave (
    input  Start, OpSub, OpA, OpB, AluOut, AluLT,
    output AluA, AluB, AluOp, Busy, Done, Result, ZeroOut, LTOut, CarryOut
  );

  // Control unit / ALU side
  modport master (
    output Start, OpSub, OpA, OpB, AluOut, AluLT,
    input  AluA, AluB, AluOp, Busy, Done, Result, ZeroOut, LTOut, CarryOut
  );
endinterface

// File: rtl/wide_arith_seq.sv
// 16-bit add/subtract built from byte passes through an external 8-bit ALU.
// Pass order: low byte, high byte, then an optional carry-correction pass
// that folds the low-byte carry/borrow into the high byte.
module wide_arith_seq #(
  parameter bit SKIP_CARRY_PASS = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  wide_arith_seq_if.slave       bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_CARRY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Operands captured with Start
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        sub_q;

  // Per-pass intermediate results
  logic [7:0]  res_lo;
  logic [7:0]  tmp_hi;
  logic        c_lo;
  logic        c_hi;

  // Registered outputs
  logic [15:0] result_q;
  logic        zero_q;
  logic        lt_q;
  logic        carry_q;

  // Combinational helpers
  logic        lo_carry;
  logic        hi_carry;
  logic        extra_carry;
  logic        need_carry;
  logic [15:0] wide_res;

  // Carry/borrow of the byte pass currently in the ALU. For an add, an
  // unsigned wrap shows up as a sum smaller than operand A; for a subtract
  // the ALU's LT flag is the borrow directly.
  assign lo_carry    = sub_q ? bus.AluLT : (bus.AluOut < a_q[7:0]);
  assign hi_carry    = sub_q ? bus.AluLT : (bus.AluOut < a_q[15:8]);

  // The correction pass can itself wrap the high byte: +1 on 0xFF or
  // -1 on 0x00.
  assign extra_carry = c_lo & (sub_q ? (tmp_hi == 8'h00) : (tmp_hi == 8'hFF));

  assign need_carry  = c_lo | (SKIP_CARRY_PASS == 1'b0);

  // Result candidate formed from the current ALU output and the low byte
  assign wide_res    = {bus.AluOut, res_lo};

  assign dbg_state   = state;

  assign bus.Result   = result_q;
  assign bus.ZeroOut  = zero_q;
  assign bus.LTOut    = lt_q;
  assign bus.CarryOut = carry_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed pass order, CARRY pass only when needed
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = bus.Start ? S_LO : S_IDLE;
      S_LO:    state_nxt = S_HI;
      S_HI:    state_nxt = need_carry ? S_CARRY : S_DONE;
      S_CARRY: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: ALU drive per pass, Busy and the Done strobe
  always_comb begin
    bus.AluA  = 8'h00;
    bus.AluB  = 8'h00;
    bus.AluOp = 1'b0;
    bus.Busy  = 1'b1;
    bus.Done  = 1'b0;
    case (state)
      S_IDLE: begin
        bus.Busy = 1'b0;
      end
      S_LO: begin
        bus.AluA  = a_q[7:0];
        bus.AluB  = b_q[7:0];
        bus.AluOp = sub_q;
      end
      S_HI: begin
        bus.AluA  = a_q[15:8];
        bus.AluB  = b_q[15:8];
        bus.AluOp = sub_q;
      end
      S_CARRY: begin
        bus.AluA  = tmp_hi;
        bus.AluB  = {7'b0, c_lo};
        bus.AluOp = sub_q;
      end
      S_DONE: begin
        bus.Done = 1'b1;
      end
      default: begin
        bus.Busy = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, per-pass results and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      sub_q    <= 1'b0;
      res_lo   <= 8'h00;
      tmp_hi   <= 8'h00;
      c_lo     <= 1'b0;
      c_hi     <= 1'b0;
      result_q <= 16'h0000;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            a_q   <= bus.OpA;
            b_q   <= bus.OpB;
            sub_q <= bus.OpSub;
          end
        end
        S_LO: begin
          res_lo <= bus.AluOut;
          c_lo   <= lo_carry;
        end
        S_HI: begin
          tmp_hi <= bus.AluOut;
          c_hi   <= hi_carry;
          if (!need_carry) begin
            result_q <= wide_res;
            zero_q   <= (wide_res == 16'h0000);
            lt_q     <= (a_q < b_q);
            carry_q  <= hi_carry;
          end
        end
        S_CARRY: begin
          result_q <= wide_res;
          zero_q   <= (wide_res == 16'h0000);
          lt_q     <= (a_q < b_q);
          carry_q  <= c_hi | extra_carry;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_arith_seq.sv
// Bench for wide_arith_seq: two instances (carry pass skipped / always run)
// share one stimulus stream, each with its own behavioural 8-bit ALU.
module tb_wide_arith_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  dbg1;
  logic [2:0]  dbg0;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {Result, ZeroOut, LTOut, CarryOut}
  logic [18:0] exp_q[$];
  logic [18:0] exp0_q[$];

  wide_arith_seq_if bus1 ();
  wide_arith_seq_if bus0 ();

  assign bus1.Start = start;
  assign bus1.OpSub = op_sub;
  assign bus1.OpA   = op_a;
  assign bus1.OpB   = op_b;
  assign bus0.Start = start;
  assign bus0.OpSub = op_sub;
  assign bus0.OpA   = op_a;
  assign bus0.OpB   = op_b;

  // 8-bit ALU models
  assign bus1.AluOut = bus1.AluOp ? (bus1.AluA - bus1.AluB) : (bus1.AluA + bus1.AluB);
  assign bus1.AluLT  = (bus1.AluA < bus1.AluB);
  assign bus0.AluOut = bus0.AluOp ? (bus0.AluA - bus0.AluB) : (bus0.AluA + bus0.AluB);
  assign bus0.AluLT  = (bus0.AluA < bus0.AluB);

  wide_arith_seq #(.SKIP_CARRY_PASS(1'b1)) u_dut1 (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus1),
    .dbg_state (dbg1)
  );

  wide_arith_seq #(.SKIP_CARRY_PASS(1'b0)) u_dut0 (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus0),
    .dbg_state (dbg0)
  );

  // Clock
  always #5 clk = ~clk;

  // Hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare_out(input string who, input logic [18:0] exp,
                             input logic [15:0] r, input logic z,
                             input logic l, input logic c);
    check({who, "_result"}, 32'(r), 32'(exp[18:3]));
    check({who, "_zero"},   32'(z), 32'(exp[2]));
    check({who, "_lt"},     32'(l), 32'(exp[1]));
    check({who, "_carry"},  32'(c), 32'(exp[0]));
  endtask

  task automatic check_idle_outputs(input string who, input logic [7:0] a,
                                    input logic [7:0] b, input logic op,
                                    input logic busy, input logic done);
    check({who, "_idle_alu_a"}, 32'(a), 32'h0);
    check({who, "_idle_alu_b"}, 32'(b), 32'h0);
    check({who, "_idle_alu_op"}, 32'(op), 32'h0);
    check({who, "_idle_busy"}, 32'(busy), 32'h0);
    check({who, "_idle_done"}, 32'(done), 32'h0);
  endtask

  // Issue one operation and check both instances against the model
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [16:0] wide;
    logic [18:0] exp;
    logic        lo_c;
    int          exp_lat;
    int          lat1;
    int          lat0;
    wide = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    exp  = {wide[15:0], (wide[15:0] == 16'h0), (a < b), wide[16]};
    lo_c = sub ? (a[7:0] < b[7:0]) : (({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'h0FF);
    exp_lat = lo_c ? 4 : 3;
    exp_q.push_back(exp);
    exp0_q.push_back(exp);
    @(negedge clk);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    op_sub = sub;
    lat1 = 0;
    lat0 = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        // Scramble inputs right after acceptance; the result must not move
        start  = 1'b0;
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        op_sub = ~sub;
      end
      if (n == 2) begin
        check("hi_pass_alu_a",  32'(bus1.AluA),  32'(a[15:8]));
        check("hi_pass_alu_b",  32'(bus1.AluB),  32'(b[15:8]));
        check("hi_pass_alu_op", 32'(bus1.AluOp), 32'(sub));
      end
      if (bus1.Done === 1'b1 && lat1 == 0) begin
        lat1 = n;
        compare_out("dut1", exp_q.pop_front(), bus1.Result, bus1.ZeroOut, bus1.LTOut, bus1.CarryOut);
      end else if (lat1 != 0 && n == lat1 + 1) begin
        check_idle_outputs("dut1_after_done", bus1.AluA, bus1.AluB, bus1.AluOp, bus1.Busy, bus1.Done);
      end
      if (bus0.Done === 1'b1 && lat0 == 0) begin
        lat0 = n;
        compare_out("dut0", exp0_q.pop_front(), bus0.Result, bus0.ZeroOut, bus0.LTOut, bus0.CarryOut);
      end
    end
    check("dut1_latency", 32'(lat1), 32'(exp_lat));
    check("dut0_latency", 32'(lat0), 32'd4);
    if (lat1 == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    if (lat0 == 0 && exp0_q.size() > 0) void'(exp0_q.pop_front());
  endtask

  initial begin
    int cnt1;
    int cnt0;
    int back1;
    logic prev1;

    // Reset
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    op_a   = 16'h0;
    op_b   = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_state",  32'(dbg1), 32'd0);
    check("rst_result", 32'(bus1.Result), 32'h0);
    check("rst_flags",  32'({bus1.ZeroOut, bus1.LTOut, bus1.CarryOut}), 32'h0);
    check_idle_outputs("rst", bus1.AluA, bus1.AluB, bus1.AluOp, bus1.Busy, bus1.Done);

    // Directed cases
    run_op(16'h1234, 16'h0101, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h0100, 16'h0001, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b1);
    run_op(16'hABCD, 16'hABCD, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b1);

    // Random cases
    for (int i = 0; i < 10; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Start held high: one operation per issue interval
    @(negedge clk);
    start  = 1'b1;
    op_a   = 16'h1234;
    op_b   = 16'h0101;
    op_sub = 1'b0;
    cnt1  = 0;
    cnt0  = 0;
    back1 = 0;
    prev1 = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      if (bus1.Done === 1'b1) cnt1++;
      if (bus0.Done === 1'b1) cnt0++;
      if (bus1.Done === 1'b1 && prev1 === 1'b1) back1++;
      prev1 = bus1.Done;
    end
    start = 1'b0;
    check("held_dut1_pulses", 32'(cnt1), 32'd4);
    check("held_dut0_pulses", 32'(cnt0), 32'd3);
    check("held_done_width",  32'(back1), 32'd0);
    check("held_result", 32'(bus1.Result), 32'h1335);
    repeat (6) @(posedge clk);

    // Reset in the HI pass abandons the operation
    @(negedge clk);
    start  = 1'b1;
    op_a   = 16'h1234;
    op_b   = 16'h0101;
    op_sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_hi", 32'(dbg1), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_state",  32'(dbg1), 32'd0);
    check("abort_result", 32'(bus1.Result), 32'h0);
    check("abort_flags",  32'({bus1.ZeroOut, bus1.LTOut, bus1.CarryOut}), 32'h0);
    check_idle_outputs("abort", bus1.AluA, bus1.AluB, bus1.AluOp, bus1.Busy, bus1.Done);
    check("abort_dut0_result", 32'(bus0.Result), 32'h0);
    check("abort_dut0_state", 32'(dbg0), 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'({bus1.Done, bus0.Done}), 32'h0);
    end

    // Fresh operation after reset
    run_op(16'h0F0F, 16'h0101, 1'b0);
    run_op(16'h1234, 16'h0101, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size() + exp0_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wide_arith_seq.md
Name: wide_arith_seq

Overview:
- 16-bit add/subtract sequencer sitting directly upstream and downstream of the 8-bit datapath ALU.
- Splits a 16-bit operation into byte passes and drives the ALU operand/op inputs.
- Consumes the ALU's Out and LT each cycle, derives carry/borrow, and applies a carry-correction pass to the high byte.
- Returns a registered 16-bit result with Zero, LT and CarryOut flags to the control unit.

Parameters:
SKIP_CARRY_PASS  1  1: omit the CARRY pass when the low-byte carry/borrow is 0; 0: always run it, with the ALU's InputB driven to 0.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
OpSub  input  1  0 = add, 1 = subtract; latched with Start
OpA  input  16  operand A; latched with Start
OpB  input  16  operand B; latched with Start
AluA  output  8  to ALU InputA
AluB  output  8  to ALU InputB
AluOp  output  1  to ALU OP (0 add, 1 sub)
AluOut  input  8  from ALU Out (combinational, same cycle)
AluLT  input  1  from ALU LT (InputA < InputB, unsigned)
Busy  output  1  high in any state other than IDLE
Done  output  1  one-cycle pulse, result valid
Result  output  16  registered result; held until the next accepted Start
ZeroOut  output  1  Result == 0; registered with Result
LTOut  output  1  unsigned OpA < OpB; registered with Result
CarryOut  output  1  add: carry out of bit 15; sub: borrow out of bit 15

Behaviour:
- Reset, synchronous, wins over everything:
  - state <= IDLE.
  - Result, ZeroOut, LTOut, CarryOut, Done, Busy <= 0.
  - All internal latches are cleared.
  - An operation in flight is abandoned with no Done.
- ALU drive:
  - Combinational from state and latched operands.
  - In IDLE and DONE: AluA = 0, AluB = 0, AluOp = 0.
- States: IDLE, LO, HI, CARRY, DONE.
- IDLE:
  - If Start = 1, latch OpA, OpB and OpSub, then go to LO.
  - Start is ignored in every other state; no queuing.
- LO:
  - Drive AluA = A[7:0], AluB = B[7:0], AluOp = sub.
  - At the clock edge: res_lo <= AluOut.
  - c_lo <= sub ? AluLT : (AluOut < A[7:0]).
  - Go to HI.
- HI:
  - Drive AluA = A[15:8], AluB = B[15:8], AluOp = sub.
  - At the clock edge: tmp_hi <= AluOut.
  - c_hi <= sub ? AluLT : (AluOut < A[15:8]).
  - Go to CARRY when c_lo = 1 or SKIP_CARRY_PASS = 0; otherwise write Result = {AluOut, res_lo} and go to DONE.
- CARRY:
  - Drive AluA = tmp_hi, AluB = {7'b0, c_lo}, AluOp = sub.
  - At the clock edge: Result <= {AluOut, res_lo}.
  - Extra carry: add with tmp_hi == 8'hFF and c_lo = 1; sub with tmp_hi == 8'h00 and c_lo = 1.
  - Final carry = c_hi | extra. Go to DONE.
- DONE:
  - Done = 1 for exactly one cycle; Busy = 1.
  - Next state is IDLE unconditionally.
  - A Start asserted during DONE is ignored.
- Flags (registered on the same edge as Result):
  - ZeroOut = (Result == 0).
  - LTOut = (A < B) as a 16-bit unsigned compare, independent of OpSub.
  - CarryOut = final carry.
  - Without a CARRY pass, CarryOut = c_hi.
- Latency, counted from the edge that samples Start:
  - Done is visible after 3 edges when the CARRY pass is skipped, after 4 edges otherwise.
  - Minimum issue interval: 4 cycles (skip case) or 5 cycles.
- Arithmetic is modulo 2^16; wrap-around is reported only through CarryOut.
- Outputs hold their values between operations.

Test Plan:
- Add, no carry: 0x1234 + 0x0101 -> Result 0x1335, CarryOut 0, ZeroOut 0, LTOut 0; Done 3 edges after Start.
- Add with carry and carry pass: 0x00FF + 0x0001 -> Result 0x0100, CarryOut 0; Done 4 edges after Start. Also 0xFFFF + 0x0001 -> Result 0x0000, ZeroOut 1, CarryOut 1, LTOut 0.
- Subtract with borrow: 0x0100 - 0x0001 -> Result 0x00FF, CarryOut 0, LTOut 0. Also 0x0000 - 0x0001 -> Result 0xFFFF, CarryOut 1, LTOut 1.
- Equal operands: 0xABCD - 0xABCD -> Result 0x0000, ZeroOut 1, LTOut 0, CarryOut 0.
- Protocol: Start held high continuously -> exactly one operation per issue interval. Operand changes after acceptance do not affect Result. Done stays a single-cycle pulse. AluA, AluB and AluOp are all 0 in IDLE.
- Reset asserted in the HI state -> next cycle IDLE with all outputs 0 and no Done pulse. A fresh Start then completes normally.
- SKIP_CARRY_PASS = 0: 0x1234 + 0x0101 -> Result 0x1335 with Done 4 edges after Start.
